// File: rtl/incline_integrator.sv
// Calibrates gyro roll-rate offset, then integrates offset-corrected roll rate fused with accel incline.
// Latency: incline/incline_vld one cycle after vld; no backpressure (vld strobes accepted every cycle).
module incline_integrator #(
  parameter int CAL_LOG2 = 4,
  parameter int FUSION   = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [15:0] roll_rt,
  input  logic [15:0] AY,
  input  logic        recal,
  output logic        cal_done,
  output logic [12:0] incline,
  output logic        incline_vld
);

  localparam int ACC_W = 16 + CAL_LOG2;
  localparam logic signed [28:0] INT_MAX = 29'sd67108863;
  localparam logic signed [28:0] INT_MIN = -29'sd67108864;

  typedef enum logic {CAL, RUN} state_t;

  state_t                    state_q, state_d;
  logic [CAL_LOG2-1:0]       smpl_cnt_q, smpl_cnt_d;
  logic signed [ACC_W-1:0]   cal_acc_q, cal_acc_d;
  logic signed [15:0]        offset_q, offset_d;
  logic signed [26:0]        roll_int_q, roll_int_d;
  logic                      cal_done_q, cal_done_d;
  logic [12:0]               incline_q, incline_d;
  logic                      incline_vld_q, incline_vld_d;

  logic signed [ACC_W-1:0]   cal_sum;
  logic signed [16:0]        roll_comp;
  logic signed [12:0]        inc_acc;
  logic signed [12:0]        inc_rate;
  logic signed [28:0]        fus;
  logic signed [28:0]        int_sum;
  logic signed [26:0]        int_sat;

  always_comb begin
    cal_sum   = cal_acc_q + {{CAL_LOG2{roll_rt[15]}}, roll_rt};
    roll_comp = $signed({roll_rt[15], roll_rt}) - $signed({offset_q[15], offset_q});
    inc_acc   = $signed(AY[15:3]);
    inc_rate  = $signed(roll_int_q[26:14]);

    if (inc_acc > inc_rate)      fus = 29'(FUSION);
    else if (inc_acc < inc_rate) fus = -29'(FUSION);
    else                         fus = '0;

    int_sum = $signed({{2{roll_int_q[26]}}, roll_int_q})
            + $signed({{12{roll_comp[16]}}, roll_comp})
            + fus;
    // Clamp rather than wrap so a sustained large rate pins the incline at full scale.
    if (int_sum > INT_MAX)      int_sat = INT_MAX[26:0];
    else if (int_sum < INT_MIN) int_sat = INT_MIN[26:0];
    else                        int_sat = int_sum[26:0];
  end

  always_comb begin
    state_d       = state_q;
    smpl_cnt_d    = smpl_cnt_q;
    cal_acc_d     = cal_acc_q;
    offset_d      = offset_q;
    roll_int_d    = roll_int_q;
    cal_done_d    = cal_done_q;
    incline_d     = incline_q;
    incline_vld_d = 1'b0;

    if (recal) begin
      // Offset is kept until the fresh calibration lands; the colliding sample is dropped.
      state_d    = CAL;
      smpl_cnt_d = '0;
      cal_acc_d  = '0;
      roll_int_d = '0;
      cal_done_d = 1'b0;
      incline_d  = '0;
    end else if (vld) begin
      case (state_q)
        CAL: begin
          if (&smpl_cnt_q) begin
            offset_d   = cal_sum[ACC_W-1:CAL_LOG2];
            cal_acc_d  = '0;
            smpl_cnt_d = '0;
            roll_int_d = '0;
            state_d    = RUN;
            cal_done_d = 1'b1;
          end else begin
            cal_acc_d  = cal_sum;
            smpl_cnt_d = smpl_cnt_q + 1'b1;
          end
        end
        RUN: begin
          roll_int_d    = int_sat;
          incline_d     = int_sat[26:14];
          incline_vld_d = 1'b1;
        end
        default: state_d = CAL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CAL;
      smpl_cnt_q    <= '0;
      cal_acc_q     <= '0;
      offset_q      <= '0;
      roll_int_q    <= '0;
      cal_done_q    <= 1'b0;
      incline_q     <= '0;
      incline_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      smpl_cnt_q    <= smpl_cnt_d;
      cal_acc_q     <= cal_acc_d;
      offset_q      <= offset_d;
      roll_int_q    <= roll_int_d;
      cal_done_q    <= cal_done_d;
      incline_q     <= incline_d;
      incline_vld_q <= incline_vld_d;
    end
  end

  assign cal_done    = cal_done_q;
  assign incline     = incline_q;
  assign incline_vld = incline_vld_q;

endmodule

// File: tb/tb_incline_integrator.sv
// Directed bench for incline_integrator: calibration, integration, fusion, saturation, recal.
module tb_incline_integrator;

  logic        clk;
  logic        rst_n;
  logic        vld;
  logic [15:0] roll_rt;
  logic [15:0] AY;
  logic        recal;
  logic        cal_done;
  logic [12:0] incline;
  logic        incline_vld;

  int n_pass  = 0;
  int n_total = 0;

  incline_integrator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vld        (vld),
    .roll_rt    (roll_rt),
    .AY         (AY),
    .recal      (recal),
    .cal_done   (cal_done),
    .incline    (incline),
    .incline_vld(incline_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic signed [31:0] inc_s();
    return 32'($signed(incline));
  endfunction

  // Present one sample for exactly one rising edge; returns at the following negedge.
  task automatic send(input int rr, input int ay);
    vld     = 1'b1;
    roll_rt = 16'(rr);
    AY      = 16'(ay);
    @(negedge clk);
    vld     = 1'b0;
  endtask

  task automatic send_n(input int n, input int rr, input int ay);
    for (int i = 0; i < n; i++) send(rr, ay);
  endtask

  task automatic do_recal();
    recal = 1'b1;
    @(negedge clk);
    recal = 1'b0;
  endtask

  initial begin
    logic signed [31:0] prev;
    logic               wrapped;

    rst_n = 1'b0; vld = 1'b0; roll_rt = '0; AY = '0; recal = 1'b0;
    #1;
    chk("rst_cal_done", 32'(cal_done), 0);
    chk("rst_incline", inc_s(), 0);
    chk("rst_incline_vld", 32'(incline_vld), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First calibration with a 100-LSB bias
    send_n(15, 100, 0);
    chk("cal_15_not_done", 32'(cal_done), 0);
    send(100, 0);
    chk("cal_16_done", 32'(cal_done), 1);
    chk("cal_no_vld", 32'(incline_vld), 0);
    chk("cal_incline_0", inc_s(), 0);

    // Bias fully removed by offset
    send(100, 0);
    chk("run_vld_pulse", 32'(incline_vld), 1);
    chk("run_bias_incline", inc_s(), 0);
    @(negedge clk);
    chk("run_vld_drop", 32'(incline_vld), 0);
    send(100, 0);
    send(100, 0);
    chk("run_bias_incline_b2b", inc_s(), 0);
    chk("run_vld_b2b", 32'(incline_vld), 1);

    // Recal, partial CAL, recal again: count restarts
    do_recal();
    chk("recal_cal_done", 32'(cal_done), 0);
    send_n(5, 50, 0);
    do_recal();
    send_n(15, 0, 0);
    chk("recal_cal_restart_15", 32'(cal_done), 0);
    send(0, 0);
    chk("recal_cal_restart_16", 32'(cal_done), 1);

    // Integration, offset 0: 16384 -> 32256 -> 48128
    send(16384, 0);
    chk("int_step1", inc_s(), 1);
    send(16384, 0);
    chk("int_step2", inc_s(), 1);
    send(16384, 0);
    chk("int_step3", inc_s(), 2);

    // Fusion alone: +512 per sample from zero
    do_recal();
    send_n(16, 0, 0);
    send_n(31, 0, 800);
    chk("fus_31", inc_s(), 0);
    send(0, 800);
    chk("fus_32", inc_s(), 1);

    // Positive saturation
    wrapped = 1'b0;
    prev = inc_s();
    for (int i = 0; i < 3000; i++) begin
      send(32767, 32767);
      if (inc_s() < prev) wrapped = 1'b1;
      prev = inc_s();
    end
    chk("sat_pos_incline", inc_s(), 4095);
    chk("sat_pos_no_wrap", 32'(wrapped), 0);

    // Negative saturation
    wrapped = 1'b0;
    prev = inc_s();
    for (int i = 0; i < 5000; i++) begin
      send(-32768, -32768);
      if (inc_s() > prev) wrapped = 1'b1;
      prev = inc_s();
    end
    chk("sat_neg_incline", inc_s(), -4096);
    chk("sat_neg_no_wrap", 32'(wrapped), 0);

    // Build incline=5: 20512, 41024, 61536, 82048
    do_recal();
    send_n(16, 0, 0);
    send_n(4, 20000, 40);
    chk("pre_collide_incline", inc_s(), 5);

    // recal and vld in the same cycle: recal wins, sample dropped
    recal = 1'b1; vld = 1'b1; roll_rt = 16'd20000; AY = 16'd40;
    @(negedge clk);
    recal = 1'b0; vld = 1'b0;
    chk("collide_cal_done", 32'(cal_done), 0);
    chk("collide_incline", inc_s(), 0);
    chk("collide_no_vld", 32'(incline_vld), 0);
    send_n(15, 0, 0);
    chk("collide_15_not_done", 32'(cal_done), 0);
    send(0, 0);
    chk("collide_16_done", 32'(cal_done), 1);
    send(16384, 0);
    chk("collide_offset0", inc_s(), 1);
    chk("pre_rst_vld", 32'(incline_vld), 1);

    // Mid-stream async reset
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cal_done", 32'(cal_done), 0);
    chk("mid_rst_incline", inc_s(), 0);
    chk("mid_rst_incline_vld", 32'(incline_vld), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
